dram_cache_fill: RTL and testbench



---
 rtl/dram_cache_fill.sv | 144 ++++++++++++++
 tb/tb_dram_cache_fill.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cache_fill.sv
// Arbitrates cache-line fills (dirty) and memory refills (clean) into single-beat AXI writes
// carrying a {valid, dirty, tag, pad} tag word ahead of the line data.
module dram_cache_fill #(
    parameter int unsigned         ADDR_WIDTH      = 32,
    parameter int unsigned         DATA_WIDTH      = 512,
    parameter int unsigned         ID_WIDTH        = 4,
    parameter int unsigned         TAG_WIDTH       = 6,
    parameter int unsigned         BLANK_WIDTH     = 56,
    parameter int unsigned         TAG_SIZE        = 2 + TAG_WIDTH + BLANK_WIDTH,
    parameter int unsigned         INDEX_WIDTH     = 20,
    parameter int unsigned         OFFSET_WIDTH    = 6,
    parameter logic [ID_WIDTH-1:0] AWID_VALUE      = '0,
    parameter int unsigned         MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fill_valid_i,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_i,
    output logic                             fill_ready_o,
    input  logic                             refill_valid_i,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] refill_data_i,
    output logic                             refill_ready_o,
    output logic [ID_WIDTH-1:0]              awid_o,
    output logic [ADDR_WIDTH-1:0]            awaddr_o,
    output logic                             awvalid_o,
    input  logic                             awready_i,
    output logic [TAG_SIZE+DATA_WIDTH-1:0]   wdata_o,
    output logic                             wlast_o,
    output logic                             wvalid_o,
    input  logic                             wready_i,
    input  logic [ID_WIDTH-1:0]              bid_i,
    input  logic [1:0]                       bresp_i,
    input  logic                             bvalid_i,
    output logic                             bready_o,
    output logic                             err_o
);

    localparam int unsigned TagLsb = INDEX_WIDTH + OFFSET_WIDTH;
    localparam int unsigned TagW   = ADDR_WIDTH - TagLsb;
    localparam int unsigned CntW   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);

    typedef enum logic {StIdle, StSend} state_e;

    state_e                           state_q, state_d;
    logic                             aw_pend_q, aw_pend_d;
    logic                             w_pend_q, w_pend_d;
    logic                             rr_refill_q, rr_refill_d;
    logic                             err_q, err_d;
    logic [CntW-1:0]                  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]            awaddr_q, awaddr_d;
    logic [TAG_SIZE+DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic                             can_accept, grant_fill, grant_refill, accept;
    logic                             b_hs, b_dec;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] cap_line;
    logic [ADDR_WIDTH-1:0]            cap_addr;
    logic [DATA_WIDTH-1:0]            cap_data;
    logic                             unused_bid;

    assign unused_bid = ^bid_i;

    always_comb begin
        // Readies are held low during reset so nothing can look accepted before release.
        can_accept   = rst_n && (state_q == StIdle) && (cnt_q < CntMax);
        grant_refill = can_accept && refill_valid_i && (!fill_valid_i || rr_refill_q);
        grant_fill   = can_accept && fill_valid_i && !grant_refill;
        accept       = grant_fill || grant_refill;
        b_hs         = bvalid_i && bready_o;
        b_dec        = b_hs && (cnt_q != '0);

        cap_line = grant_refill ? refill_data_i : fill_data_i;
        cap_addr = cap_line[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
        cap_data = cap_line[DATA_WIDTH-1:0];

        state_d     = state_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        rr_refill_d = rr_refill_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;

        if (accept) begin
            state_d   = StSend;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            awaddr_d  = {{TagW{1'b0}}, cap_addr[TagLsb-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            wdata_d   = {1'b1, grant_fill, cap_addr[ADDR_WIDTH-1:TagLsb],
                         {BLANK_WIDTH{1'b0}}, cap_data};
            // Priority only moves when both sources competed for this grant.
            if (fill_valid_i && refill_valid_i) begin
                rr_refill_d = !rr_refill_q;
            end
        end else if (state_q == StSend) begin
            aw_pend_d = aw_pend_q && !awready_i;
            w_pend_d  = w_pend_q && !wready_i;
            if (!aw_pend_d && !w_pend_d) begin
                state_d = StIdle;
            end
        end

        unique case ({accept, b_dec})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q || (b_hs && (bresp_i != 2'b00));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            rr_refill_q <= 1'b1;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            rr_refill_q <= rr_refill_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign fill_ready_o   = grant_fill;
    assign refill_ready_o = grant_refill;
    assign awid_o         = AWID_VALUE;
    assign awaddr_o       = awaddr_q;
    assign awvalid_o      = aw_pend_q;
    assign wdata_o        = wdata_q;
    assign wvalid_o       = w_pend_q;
    assign wlast_o        = w_pend_q;
    assign bready_o       = rst_n;
    assign err_o          = err_q;

endmodule

// File: tb/tb_dram_cache_fill.sv
// Directed bench for dram_cache_fill: transaction-level model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_dram_cache_fill;

    localparam int unsigned LW = 64 + 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fill_valid_i = 1'b0;
    logic [543:0]  fill_data_i = '0;
    logic          fill_ready_o;
    logic          refill_valid_i = 1'b0;
    logic [543:0]  refill_data_i = '0;
    logic          refill_ready_o;
    logic [3:0]    awid_o;
    logic [31:0]   awaddr_o;
    logic          awvalid_o;
    logic          awready_i = 1'b0;
    logic [575:0]  wdata_o;
    logic          wlast_o;
    logic          wvalid_o;
    logic          wready_i = 1'b0;
    logic [3:0]    bid_i = '0;
    logic [1:0]    bresp_i = '0;
    logic          bvalid_i = 1'b0;
    logic          bready_o;
    logic          err_o;

    always #5 clk = ~clk;

    dram_cache_fill #(
        .ADDR_WIDTH(32), .DATA_WIDTH(512), .ID_WIDTH(4), .TAG_WIDTH(6), .BLANK_WIDTH(56),
        .TAG_SIZE(64), .INDEX_WIDTH(20), .OFFSET_WIDTH(6), .AWID_VALUE(4'h0),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fill_valid_i(fill_valid_i), .fill_data_i(fill_data_i), .fill_ready_o(fill_ready_o),
        .refill_valid_i(refill_valid_i), .refill_data_i(refill_data_i),
        .refill_ready_o(refill_ready_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .err_o(err_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [511:0] pat(input logic [31:0] s);
        return {16{s}};
    endfunction

    // Transaction-level model: one write in flight, a count of unanswered writes,
    // and which source gets the next contested grant.
    logic         m_busy, m_aw, m_w, m_dirty, m_any, m_pref_refill, m_err;
    logic         m_take_r, m_take_f;
    logic [31:0]  m_addr;
    logic [511:0] m_data;
    int           m_out, m_dec;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_aw = 0; m_w = 0; m_dirty = 0; m_any = 0;
            m_pref_refill = 1; m_err = 0; m_addr = '0; m_data = '0; m_out = 0;
        end else begin
            m_dec = (bvalid_i && m_out > 0) ? 1 : 0;
            if (bvalid_i && bresp_i != 2'b00) m_err = 1;
            m_take_r = 0;
            m_take_f = 0;
            if (!m_busy && m_out < 2) begin
                if (refill_valid_i && fill_valid_i) begin
                    if (m_pref_refill) m_take_r = 1;
                    else m_take_f = 1;
                    m_pref_refill = m_take_f;
                end else if (refill_valid_i) m_take_r = 1;
                else if (fill_valid_i) m_take_f = 1;
            end
            if (m_take_r || m_take_f) begin
                m_busy = 1; m_aw = 1; m_w = 1; m_any = 1;
                m_dirty = m_take_f;
                {m_addr, m_data} = m_take_r ? refill_data_i : fill_data_i;
                m_out++;
            end else if (m_busy) begin
                if (awready_i) m_aw = 0;
                if (wready_i) m_w = 0;
                if (!m_aw && !m_w) m_busy = 0;
            end
            m_out -= m_dec;
        end
    end

    logic [31:0]  e_awaddr;
    logic [575:0] e_wdata;
    logic         e_fr, e_rr;
    bit           g_log[$];

    always @(negedge clk) begin
        if (rst_n) begin
            e_awaddr = (m_addr % 32'h0400_0000) / 64 * 64;
            e_wdata  = m_any ? {1'b1, m_dirty, m_addr[31:26], 56'h0, m_data} : '0;
            e_fr = !m_busy && m_out < 2 && fill_valid_i && !(refill_valid_i && m_pref_refill);
            e_rr = !m_busy && m_out < 2 && refill_valid_i && !(fill_valid_i && !m_pref_refill);
            check("fill_ready", fill_ready_o, e_fr);
            check("refill_ready", refill_ready_o, e_rr);
            check("awvalid", awvalid_o, m_busy && m_aw);
            check("wvalid", wvalid_o, m_busy && m_w);
            check("wlast", wlast_o, m_busy && m_w);
            check("awaddr", awaddr_o, e_awaddr);
            check("wdata", wdata_o, e_wdata);
            check("err", err_o, m_err);
            check("bready", bready_o, 1'b1);
            check("awid", awid_o, 4'h0);
            if (fill_valid_i && fill_ready_o) g_log.push_back(1'b0);
            if (refill_valid_i && refill_ready_o) g_log.push_back(1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [1:0] resp);
        bvalid_i = 1'b1;
        bresp_i  = resp;
        tick();
        bvalid_i = 1'b0;
        bresp_i  = 2'b00;
    endtask

    task automatic single_write(input bit use_refill, input logic [31:0] addr,
                                input logic [511:0] data, input logic [7:0] exp_top,
                                input string tag);
        if (use_refill) begin
            refill_valid_i = 1'b1;
            refill_data_i  = {addr, data};
        end else begin
            fill_valid_i = 1'b1;
            fill_data_i  = {addr, data};
        end
        tick();
        fill_valid_i   = 1'b0;
        refill_valid_i = 1'b0;
        check({tag, "_awvalid_t1"}, awvalid_o, 1'b1);
        check({tag, "_wvalid_t1"}, wvalid_o, 1'b1);
        check({tag, "_awaddr"}, awaddr_o, 32'h0123_4540);
        check({tag, "_tag_byte"}, wdata_o[575:568], exp_top);
        check({tag, "_data"}, wdata_o[511:0], data);
        tick();
        check({tag, "_awvalid_t2"}, awvalid_o, 1'b0);
        check({tag, "_wvalid_t2"}, wvalid_o, 1'b0);
        send_b(2'b00);
    endtask

    bit exp_order[4];

    initial begin
        // Reset state
        #1;
        check("rst_awvalid", awvalid_o, 1'b0);
        check("rst_wvalid", wvalid_o, 1'b0);
        check("rst_wlast", wlast_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_bready", bready_o, 1'b0);
        check("rst_awaddr", awaddr_o, 32'h0);
        check("rst_wdata", wdata_o, '0);
        check("rst_awid", awid_o, 4'h0);
        fill_valid_i = 1'b1;
        #1;
        check("rst_fill_ready", fill_ready_o, 1'b0);
        fill_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        awready_i = 1'b1;
        wready_i  = 1'b1;
        tick();

        // Scenarios 1 and 2: dirty fill then clean refill of the same line
        single_write(1'b0, 32'hC123_4540, pat(32'hA5A5_0001), 8'hF0, "s1");
        single_write(1'b1, 32'hC123_4540, pat(32'h5A5A_0002), 8'hB0, "s2");

        // Scenario 3: both sources held, round-robin from refill
        g_log.delete();
        fill_data_i    = {32'h8000_1000, pat(32'h1111_0003)};
        refill_data_i  = {32'h4000_2040, pat(32'h2222_0004)};
        fill_valid_i   = 1'b1;
        refill_valid_i = 1'b1;
        bvalid_i       = 1'b1;
        for (int i = 0; i < 40 && g_log.size() < 4; i++) tick();
        fill_valid_i   = 1'b0;
        refill_valid_i = 1'b0;
        check("s3_grant_count", 32'(g_log.size()), 32'd4);
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i < g_log.size()) check($sformatf("s3_grant%0d", i), g_log[i], exp_order[i]);
        end
        tick();
        tick();
        bvalid_i = 1'b0;

        // Scenario 4: outstanding cap of 2
        g_log.delete();
        fill_data_i  = {32'h0000_0080, pat(32'h3333_0005)};
        fill_valid_i = 1'b1;
        repeat (6) tick();
        check("s4_accepts_at_cap", 32'(g_log.size()), 32'd2);
        check("s4_ready_at_cap", fill_ready_o, 1'b0);
        bvalid_i = 1'b1;
        #1;
        check("s4_ready_b_cycle", fill_ready_o, 1'b0);
        tick();
        bvalid_i = 1'b0;
        #1;
        check("s4_ready_after_b", fill_ready_o, 1'b1);
        tick();
        fill_valid_i = 1'b0;
        check("s4_third_accept", 32'(g_log.size()), 32'd3);
        tick();
        bvalid_i = 1'b1;
        tick();
        tick();
        bvalid_i = 1'b0;
        check("s4_err", err_o, 1'b0);

        // Scenario 5: W channel stalls until T+4, then an error response
        wready_i     = 1'b0;
        fill_data_i  = {32'hFC00_0FC0, pat(32'h4444_0006)};
        fill_valid_i = 1'b1;
        tick();
        fill_valid_i = 1'b0;
        check("s5_awvalid_t1", awvalid_o, 1'b1);
        check("s5_wvalid_t1", wvalid_o, 1'b1);
        check("s5_awaddr", awaddr_o, 32'h0000_0FC0);
        tick();
        check("s5_awvalid_t2", awvalid_o, 1'b0);
        check("s5_wvalid_t2", wvalid_o, 1'b1);
        tick();
        check("s5_wvalid_t3", wvalid_o, 1'b1);
        tick();
        check("s5_wvalid_t4", wvalid_o, 1'b1);
        wready_i = 1'b1;
        tick();
        check("s5_wvalid_t5", wvalid_o, 1'b0);
        fill_valid_i = 1'b1;
        #1;
        check("s5_idle_t5", fill_ready_o, 1'b1);
        fill_valid_i = 1'b0;
        send_b(2'b10);
        check("s5_err_set", err_o, 1'b1);
        repeat (3) tick();
        check("s5_err_sticky", err_o, 1'b1);

        // Scenario 6: asynchronous reset during S_SEND
        fill_data_i  = {32'h1234_5678, pat(32'h5555_0007)};
        fill_valid_i = 1'b1;
        tick();
        fill_valid_i = 1'b0;
        check("s6_awvalid_before", awvalid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_awvalid_async", awvalid_o, 1'b0);
        check("s6_wvalid_async", wvalid_o, 1'b0);
        check("s6_err_cleared", err_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        single_write(1'b0, 32'hC123_4540, pat(32'h6666_0008), 8'hF0, "s6");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
